// File: rtl/cdc_rx_width_downsizer_pkg.sv
// Shared helpers for the clock-domain-crossing block and its width converters.
// Holds the ceil-log2 helper, the width-ratio legality check and the drain FSM states.
package cdc_rx_width_downsizer_pkg;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A downsizer needs a whole number of slices per word and at least two of them.
    function automatic bit width_ratio_legal(input int in_width, input int out_width);
        if (out_width <= 0) begin
            return 1'b0;
        end
        return ((in_width % out_width) == 0) && ((in_width / out_width) >= 2);
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/cdc_rx_width_downsizer.sv
// Destination-domain downsizer: takes wide words from the crossing and replays each one
// as RATIO narrow slices, reloading on the last slice so the stream never bubbles.
module cdc_rx_width_downsizer
    import cdc_rx_width_downsizer_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if (!width_ratio_legal(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
            $error("cdc_rx_width_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
        end
    endgenerate

    drain_state_t         state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [IN_WIDTH-1:0]  word_reg, word_next;
    logic                 last_reg, last_next;

    logic                 loaded;
    logic                 on_last_slice;
    logic                 in_fire;
    logic                 out_fire;
    logic [OUT_WIDTH-1:0] slices [RATIO];

    assign loaded        = (state_reg == ST_DRAIN);
    assign on_last_slice = (idx_reg == LAST_IDX);

    // in_ready looks only at state and out_ready, never at in_valid.
    assign in_ready  = !rst && (!loaded || (out_ready && on_last_slice));
    assign in_fire   = in_valid && in_ready;
    assign out_valid = loaded;
    assign out_fire  = out_valid && out_ready;
    assign out_last  = loaded && last_reg && on_last_slice;
    assign busy      = loaded;

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        if (MSB_FIRST) begin : g_msb
            assign slices[gi] = word_reg[(RATIO-1-gi)*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_lsb
            assign slices[gi] = word_reg[gi*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    assign out_data = slices[idx_reg];

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        word_next  = word_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_next = ST_DRAIN;
                    idx_next   = '0;
                    word_next  = in_data;
                    last_next  = in_last;
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    if (!on_last_slice) begin
                        idx_next = idx_reg + IDX_W'(1);
                    end else if (in_fire) begin
                        idx_next  = '0;
                        word_next = in_data;
                        last_next = in_last;
                    end else begin
                        // Word register keeps its old contents; nothing reads it while empty.
                        state_next = ST_EMPTY;
                        idx_next   = '0;
                    end
                end
            end
            default: begin
                state_next = ST_EMPTY;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            idx_reg   <= '0;
            word_reg  <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            word_reg  <= word_next;
            last_reg  <= last_next;
        end
    end

endmodule

// File: tb/tb_cdc_rx_width_downsizer.sv
// Directed bench for cdc_rx_width_downsizer: an LSB-first and an MSB-first instance
// share one stimulus stream; expected slices are written out by hand.
module tb_cdc_rx_width_downsizer;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_last0, busy0;
    logic [7:0]  out_data0;
    logic        in_ready1, out_valid1, out_last1, busy1;
    logic [7:0]  out_data1;

    int n_cmp;
    int n_bad;

    cdc_rx_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_last(out_last0), .out_ready(out_ready),
        .busy(busy0)
    );

    cdc_rx_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1), .out_ready(out_ready),
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word, confirm it is taken on this cycle, then withdraw in_valid.
    task automatic send_word(input string tag, input logic [31:0] w, input logic lst);
        in_data  = w;
        in_last  = lst;
        in_valid = 1'b1;
        @(negedge clk);
        check({tag, ".in_ready"}, in_ready0, 1'b1);
        $display("word %s: %h last=%0b accepted", tag, w, lst);
        step();
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
    endtask

    // Expect four slices on consecutive cycles with out_ready held high.
    task automatic drain(input string tag, input bit use_msb,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input logic lst);
        logic [7:0] exp_b [4];
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("%s.valid%0d", tag, k), use_msb ? out_valid1 : out_valid0, 1'b1);
            check($sformatf("%s.data%0d", tag, k), use_msb ? out_data1 : out_data0, exp_b[k]);
            check($sformatf("%s.last%0d", tag, k), use_msb ? out_last1 : out_last0, lst && (k == 3));
            $display("slice %s[%0d]: %h", tag, k, use_msb ? out_data1 : out_data0);
            step();
        end
        @(negedge clk);
        check({tag, ".idle"}, use_msb ? out_valid1 : out_valid0, 1'b0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bp_exp [4];
        bit         bp_pat [10];
        int         k;

        n_cmp = 0;
        n_bad = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        step();

        // Reset held with in_valid high
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst.in_ready%0d", c), in_ready0, 1'b0);
            check($sformatf("rst.out_valid%0d", c), out_valid0, 1'b0);
            check($sformatf("rst.out_data%0d", c), out_data0, 8'h00);
            check($sformatf("rst.busy%0d", c), busy0, 1'b0);
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rel.in_ready", in_ready0, 1'b1);
        check("rel.out_last", out_last0, 1'b0);
        $display("reset released");
        step();

        // Single word, LSB first
        send_word("single", 32'hA1B2C3D4, 1'b1);
        drain("single", 1'b0, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 1'b1);

        // Back-to-back words with no bubble
        in_valid = 1'b1;
        in_data  = 32'h03020100;
        in_last  = 1'b0;
        @(negedge clk);
        check("b2b.accept0", in_ready0, 1'b1);
        step();
        in_data = 32'h07060504;
        in_last = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("b2b.valid%0d", c), out_valid0, 1'b1);
            check($sformatf("b2b.data%0d", c), out_data0, c[7:0]);
            check($sformatf("b2b.last%0d", c), out_last0, c == 7);
            check($sformatf("b2b.in_ready%0d", c), in_ready0, (c == 3) || (c == 7));
            $display("slice b2b[%0d]: %h", c, out_data0);
            step();
            if (c == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b.idle", out_valid0, 1'b0);
        step();

        // Back-pressure with an irregular out_ready pattern
        bp_exp[0] = 8'hEF; bp_exp[1] = 8'hBE; bp_exp[2] = 8'hAD; bp_exp[3] = 8'hDE;
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        send_word("bp", 32'hDEADBEEF, 1'b0);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready = bp_pat[c];
            @(negedge clk);
            check($sformatf("bp.valid%0d", c), out_valid0, 1'b1);
            check($sformatf("bp.data%0d", c), out_data0, bp_exp[k]);
            check($sformatf("bp.in_ready%0d", c), in_ready0, bp_pat[c] && (k == 3));
            $display("cycle bp[%0d]: ready=%0b data=%h", c, bp_pat[c], out_data0);
            step();
            if (bp_pat[c]) k++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.idle", out_valid0, 1'b0);
        step();

        // MSB-first instance
        send_word("msb", 32'h11223344, 1'b1);
        drain("msb", 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);

        // Reset after two of four slices
        send_word("rstmid", 32'h55667788, 1'b0);
        @(negedge clk);
        check("rstmid.data0", out_data0, 8'h88);
        step();
        @(negedge clk);
        check("rstmid.data1", out_data0, 8'h77);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.in_ready", in_ready0, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.out_valid", out_valid0, 1'b0);
        check("rstmid.out_data", out_data0, 8'h00);
        check("rstmid.busy", busy0, 1'b0);
        $display("reset mid-word applied");
        step();
        send_word("after", 32'h0A0B0C0D, 1'b0);
        drain("after", 1'b0, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
